// File: rtl/warn_cnt_scan.sv
// ---------------------------------------------------------------------------
// warn_cnt_scan
//
// Walks an array of TB_ARR warning counters one channel per cycle and emits a
// (index, count) record for every channel whose count reaches thresh_i. Each
// record is held on a valid/ready handshake until the sink accepts it. When
// CLR_ON_READ is set, the accepted channel receives a one-cycle clear pulse
// on the cycle after acceptance.
//
// Optional build feature:
//   WARN_SCAN_SKIP_ZERO_EN - when defined, channels holding 0 never report,
//                            whatever thresh_i is. Undefined by default.
//
// Ports:
//   clk_i      in   1           clock
//   rst_i      in   1           asynchronous active-high reset
//   start_i    in   1           start-scan pulse (honoured only while idle)
//   abort_i    in   1           abandon the current scan, return to idle
//   thresh_i   in   CNT_W       report threshold (unsigned, count >= thresh)
//   warnCnt_i  in   TB_ARR*16   flat counter bus, channel i at [i*16 +: 16]
//   rdy_i      in   1           sink ready
//   vld_o      out  1           record valid
//   idx_o      out  IDX_W       channel index of the record
//   cnt_o      out  CNT_W       captured count
//   clr_o      out  TB_ARR      one-hot clear pulses to the counters
//   busy_o     out  1           scan in progress (any state but idle)
//   done_o     out  1           one-cycle pulse at scan completion
// ---------------------------------------------------------------------------
module warn_cnt_scan #(
    parameter int TB_ARR      = 256,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = 8,
    parameter int CLR_ON_READ = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CNT_W-1:0]     thresh_i,
    input  logic [TB_ARR*16-1:0] warnCnt_i,
    input  logic                 rdy_i,
    output logic                 vld_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [TB_ARR-1:0]    clr_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TB_ARR-1:0]  clr_q,   clr_d;

    logic [CNT_W-1:0]   cur_cnt;
    logic               hit;
    logic               last_ch;

    // Hit rule for one channel; the zero-skip variant is a build-time option.
    function automatic logic is_hit(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] thr);
`ifdef WARN_SCAN_SKIP_ZERO_EN
        return (cnt != '0) && (cnt >= thr);
`else
        return cnt >= thr;
`endif
    endfunction

    // Select the channel under the index. A compare-per-channel mux avoids an
    // array index wider than the array when 2**IDX_W exceeds TB_ARR.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < TB_ARR; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_cnt = warnCnt_i[i*16 +: CNT_W];
            end
        end
    end

    assign hit     = is_hit(cur_cnt, thresh_i);
    assign last_ch = (idx_q == IDX_W'(TB_ARR - 1));

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        clr_d   = '0;

        case (state_q)
            IDLE: begin
                // Start together with abort is dropped: abort wins below.
                if (start_i) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (hit) begin
                    cnt_d   = cur_cnt;
                    state_d = EMIT;
                end else if (last_ch) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            EMIT: begin
                // vld_o is high throughout EMIT, so rdy_i alone is acceptance.
                if (rdy_i) begin
                    if (CLR_ON_READ != 0) begin
                        clr_d = TB_ARR'(1) << idx_q;
                    end
                    if (last_ch) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including an acceptance on this edge:
        // no clear is issued and the index does not advance.
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = idx_q;
            clr_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    // All outputs come straight from registers, so reset clears them at once.
    assign vld_o  = (state_q == EMIT);
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign idx_o  = idx_q;
    assign cnt_o  = cnt_q;
    assign clr_o  = clr_q;

endmodule
